// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the sram-like request arbiter: source encoding, the
// outstanding-transaction tag layout and the lock FSM states.
package sram_req_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // One tag per accepted transaction; discard marks a flushed fetch.
    typedef struct packed {
        logic discard;
        logic src;
    } tag_entry_t;

    localparam int TAG_W = $bits(tag_entry_t);

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order tag FIFO for accepted-but-unanswered transactions. A bulk clear
// marks every INST entry (including one being pushed now) as discarded, and
// the head output already reflects a clear arriving in the same cycle.
module req_tag_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push_i,
    input  tag_entry_t push_entry_i,
    input  logic       pop_i,
    input  logic       clear_inst_i,
    output logic       full_o,
    output logic       empty_o,
    output tag_entry_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    tag_entry_t       entry_q [DEPTH];
    tag_entry_t       head_raw;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_raw       = entry_q[head_q];
    assign head_o.src     = head_raw.src;
    assign head_o.discard = head_raw.discard | (clear_inst_i & (head_raw.src == SRC_INST));

    // Pointer and occupancy bookkeeping; push and pop together leave count alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= ptr_inc(tail_q);
            if (do_pop)  head_q <= ptr_inc(head_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Tag storage: write at tail, and flag INST entries on a flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (tail_q == PTR_W'(i))) begin
                    entry_q[i].src     <= push_entry_i.src;
                    entry_q[i].discard <= push_entry_i.discard |
                                          (clear_inst_i & (push_entry_i.src == SRC_INST));
                end else if (clear_inst_i && (entry_q[i].src == SRC_INST)) begin
                    entry_q[i].discard <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between instruction fetch and data access.
// Data has fixed priority unless a stalled request holds the lock; responses
// come back in order and are routed by the tag FIFO head.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int CNT_W       = $clog2(OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    lock_state_t lock_q;
    logic        lock_src_q;
    logic        sel;
    logic        sel_req;
    logic        can_issue;
    logic        transfer;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop_valid;
    tag_entry_t  push_entry;
    tag_entry_t  head;

    assign can_issue = ~fifo_full;
    assign sel       = (lock_q == LOCK_HELD) ? lock_src_q : (data_req ? SRC_DATA : SRC_INST);
    assign sel_req   = (sel == SRC_DATA) ? data_req : inst_req;

    // Every output is forced low while reset is asserted.
    assign mem_req   = resetn & can_issue & sel_req;
    assign mem_wr    = resetn & ((sel == SRC_DATA) ? data_wr : inst_wr);
    assign mem_size  = resetn ? ((sel == SRC_DATA) ? data_size  : inst_size)  : '0;
    assign mem_addr  = resetn ? ((sel == SRC_DATA) ? data_addr  : inst_addr)  : '0;
    assign mem_wstrb = resetn ? ((sel == SRC_DATA) ? data_wstrb : inst_wstrb) : '0;
    assign mem_wdata = resetn ? ((sel == SRC_DATA) ? data_wdata : inst_wdata) : '0;

    assign transfer     = mem_req & mem_addr_ok;
    assign inst_addr_ok = transfer & (sel == SRC_INST);
    assign data_addr_ok = transfer & (sel == SRC_DATA);

    assign push_entry.src     = sel;
    assign push_entry.discard = (sel == SRC_INST) & inst_cancel;

    assign pop_valid    = resetn & mem_data_ok & ~fifo_empty;
    assign data_data_ok = pop_valid & (head.src == SRC_DATA);
    assign inst_data_ok = pop_valid & (head.src == SRC_INST) & ~head.discard;
    assign inst_rdata   = resetn ? mem_rdata : '0;
    assign data_rdata   = resetn ? mem_rdata : '0;

    // Lock FSM: pin the selected source while its request waits for addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q     <= LOCK_IDLE;
            lock_src_q <= SRC_DATA;
        end else begin
            case (lock_q)
                LOCK_IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        lock_q     <= LOCK_HELD;
                        lock_src_q <= sel;
                    end
                end
                LOCK_HELD: begin
                    if (transfer) lock_q <= LOCK_IDLE;
                end
                default: lock_q <= LOCK_IDLE;
            endcase
        end
    end

    req_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (transfer),
        .push_entry_i (push_entry),
        .pop_i        (mem_data_ok & resetn),
        .clear_inst_i (inst_cancel),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (head)
    );

    // A response with nothing outstanding is a downstream protocol error.
    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
                                         !(mem_data_ok && fifo_empty));

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench: stimulus pushes expected responses to a scoreboard queue,
// a negedge monitor pops and compares whenever a data_ok pulse appears.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_cancel;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0;
        inst_wstrb = 0; inst_wdata = 0; inst_cancel = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0;
        data_wstrb = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic respond(input logic is_data, input logic [31:0] rd, input logic expect_out);
        mem_data_ok = 1;
        mem_rdata   = rd;
        if (expect_out) exp_q.push_back('{is_data: is_data, rdata: rd});
    endtask

    // Scoreboard monitor: every data_ok pulse must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && (inst_data_ok === 1'b1 || data_data_ok === 1'b1)) begin
                if (inst_data_ok === 1'b1 && data_data_ok === 1'b1) begin
                    chk("both_data_ok", 32'd1, 32'd0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_data_ok", {31'd0, data_data_ok}, {31'd0, inst_data_ok});
                    checks--;
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_side", {31'd0, data_data_ok}, {31'd0, e.is_data});
                    chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
                end
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        resetn = 0;
        // Reset: outputs low even with every input active.
        inst_req = 1; data_req = 1; data_addr = 32'hFFFF_0000;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick();
        idle();
        resetn = 1;
        tick();

        // Test 1: both request together, data first.
        data_req = 1; data_addr = 32'h0000_1000;
        inst_req = 1; inst_addr = 32'h0000_2000; mem_addr_ok = 1;
        settle();
        chk("t1_data_addr_ok", data_addr_ok, 1);
        chk("t1_inst_addr_ok_c0", inst_addr_ok, 0);
        chk("t1_mem_addr_c0", mem_addr, 32'h0000_1000);
        tick();
        data_req = 0;
        settle();
        chk("t1_inst_addr_ok_c1", inst_addr_ok, 1);
        chk("t1_mem_addr_c1", mem_addr, 32'h0000_2000);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        respond(1, 32'hA5A5_A5A5, 1);
        tick();
        respond(0, 32'h1234_5678, 1);
        tick();
        idle();
        tick();

        // Test 2: lock holds the stalled inst payload while data waits.
        inst_req = 1; inst_addr = 32'h0000_3000;
        settle();
        chk("t2_mem_req_c0", mem_req, 1);
        chk("t2_mem_addr_c0", mem_addr, 32'h0000_3000);
        tick();
        data_req = 1; data_addr = 32'h0000_4000;
        settle();
        chk("t2_mem_addr_c1", mem_addr, 32'h0000_3000);
        chk("t2_data_addr_ok_c1", data_addr_ok, 0);
        tick();
        settle();
        chk("t2_mem_addr_c2", mem_addr, 32'h0000_3000);
        tick();
        mem_addr_ok = 1;
        settle();
        chk("t2_inst_addr_ok_c3", inst_addr_ok, 1);
        chk("t2_data_addr_ok_c3", data_addr_ok, 0);
        tick();
        inst_req = 0;
        settle();
        chk("t2_data_addr_ok_c4", data_addr_ok, 1);
        chk("t2_mem_addr_c4", mem_addr, 32'h0000_4000);
        tick();
        data_req = 0; mem_addr_ok = 0;
        respond(0, 32'h3333_3333, 1);
        tick();
        respond(1, 32'h4444_4444, 1);
        tick();
        idle();
        tick();

        // Test 3: full FIFO blocks issue, even on a popping cycle.
        inst_req = 1; inst_addr = 32'h0000_5000; mem_addr_ok = 1;
        settle();
        chk("t3_addr_ok_1", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h0000_5004;
        settle();
        chk("t3_addr_ok_2", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h0000_5008;
        settle();
        chk("t3_full_mem_req", mem_req, 0);
        tick();
        respond(0, 32'h5555_0000, 1);
        settle();
        chk("t3_full_pop_mem_req", mem_req, 0);
        tick();
        respond(0, 32'h5555_0004, 1);
        settle();
        chk("t3_reissue_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        respond(0, 32'h5555_0008, 1);
        tick();
        idle();
        tick();

        // Test 4: cancel discards two outstanding fetches.
        inst_req = 1; inst_addr = 32'h0000_7000; mem_addr_ok = 1;
        tick();
        inst_addr = 32'h0000_7004;
        settle();
        chk("t4_addr_ok_2", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0; inst_cancel = 1;
        tick();
        inst_cancel = 0;
        respond(0, 32'h7777_0000, 0);
        settle();
        chk("t4_drop_1", inst_data_ok, 0);
        tick();
        respond(0, 32'h7777_0004, 0);
        settle();
        chk("t4_drop_2", inst_data_ok, 0);
        tick();
        mem_data_ok = 0;
        data_req = 1; data_addr = 32'h0000_8000; mem_addr_ok = 1;
        settle();
        chk("t4_data_addr_ok", data_addr_ok, 1);
        tick();
        data_req = 0; mem_addr_ok = 0;
        respond(1, 32'hDDDD_0001, 1);
        tick();
        idle();
        tick();

        // Test 5: cancel in the same cycle as the inst push.
        inst_req = 1; inst_addr = 32'h0000_9000; mem_addr_ok = 1; inst_cancel = 1;
        settle();
        chk("t5_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; inst_cancel = 0;
        data_req = 1; data_addr = 32'h0000_A000;
        settle();
        chk("t5_data_addr_ok", data_addr_ok, 1);
        tick();
        data_req = 0; mem_addr_ok = 0;
        respond(0, 32'h9999_9999, 0);
        settle();
        chk("t5_drop", inst_data_ok, 0);
        tick();
        respond(1, 32'hBEEF_0005, 1);
        tick();
        idle();
        tick();

        // Test 6: asynchronous reset with one fetch outstanding.
        inst_req = 1; inst_addr = 32'h0000_B000; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; inst_addr = 32'h0000_B004;
        chk("t6_pre_rst_mem_req", mem_req, 1);
        #1;
        resetn = 0;
        mem_data_ok = 1; mem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("t6_async_mem_req", mem_req, 0);
        chk("t6_async_inst_data_ok", inst_data_ok, 0);
        tick();
        settle();
        chk("t6_stray_inst_data_ok", inst_data_ok, 0);
        chk("t6_stray_data_data_ok", data_data_ok, 0);
        tick();
        idle();
        resetn = 1;
        inst_req = 1; inst_addr = 32'h0000_C000; mem_addr_ok = 1;
        settle();
        chk("t6_post_addr_ok_1", inst_addr_ok, 1);
        tick();
        inst_addr = 32'h0000_C004;
        settle();
        chk("t6_post_addr_ok_2", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        respond(0, 32'hC0C0_0000, 1);
        tick();
        respond(0, 32'hC0C0_0004, 1);
        tick();
        idle();
        tick();
        tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
